// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg                                                              |
// | Shared datapath width, comparator result type and slice helpers.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int XLEN    = 16;
  localparam int SLICE_W = 4;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_res_t;

  // Number of SLICE_W-wide slices needed to cover a width, rounded up.
  function automatic int num_slices(input int width);
    return (width + SLICE_W - 1) / SLICE_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/comparator_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comparator_if                                                        |
// | Operand/result bundle between the issue logic and the comparator.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface comparator_if
  import cpu_pkg::*;
#(
  parameter int N = XLEN
) ();

  logic [N-1:0] rs1;
  logic [N-1:0] rs2;
  logic         is_signed;
  logic         valid_in;
  logic         eq;
  logic         gt;
  logic         lt;
  logic         valid_out;

  modport master (
    output rs1, rs2, is_signed, valid_in,
    input  eq, gt, lt, valid_out
  );

  modport slave (
    input  rs1, rs2, is_signed, valid_in,
    output eq, gt, lt, valid_out
  );

endinterface
`default_nettype wire

// File: rtl/comp_slice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comp_slice                                                           |
// | 4-bit unsigned comparator leaf producing equal and greater-than.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module comp_slice
  import cpu_pkg::*;
(
  input  wire  [SLICE_W-1:0] a,
  input  wire  [SLICE_W-1:0] b,
  output logic               eq,
  output logic               gt
);

  assign eq = (a == b);
  assign gt = (a > b);

endmodule
`default_nettype wire

// File: rtl/comparator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comparator                                                           |
// | Registered N-bit magnitude comparator, unsigned or two's complement. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module comparator
  import cpu_pkg::*;
#(
  parameter int N = XLEN
) (
  input  wire         clk,
  input  wire         rst,
  comparator_if.slave bus
);

  localparam int NS = num_slices(N);
  localparam int LV = (NS > 1) ? $clog2(NS) : 0;
  localparam int NP = 1 << LV;
  localparam int PW = NS * SLICE_W;

  logic [PW-1:0]   a_pad;
  logic [PW-1:0]   b_pad;
  logic [NS-1:0]   slice_eq;
  logic [NS-1:0]   slice_gt;
  logic [2*NP-2:0] tree_eq;
  logic [2*NP-2:0] tree_gt;
  cmp_res_t        core_res;
  cmp_res_t        res_d;
  cmp_res_t        res_q;
  logic            valid_d;
  logic            valid_q;

  // Zero-extension keeps the unsigned order when N is not a multiple of 4.
  assign a_pad = PW'(bus.rs1);
  assign b_pad = PW'(bus.rs2);

  generate
    for (genvar i = 0; i < NS; i++) begin : g_slice
      comp_slice u_slice (
        .a  (a_pad[i*SLICE_W +: SLICE_W]),
        .b  (b_pad[i*SLICE_W +: SLICE_W]),
        .eq (slice_eq[i]),
        .gt (slice_gt[i])
      );
    end
  endgenerate

  // Heap-ordered tree: node k has children 2k+1 (more significant) and
  // 2k+2. Leaves are placed so slice 0 lands on the right-most leaf; unused
  // leaves report equal so they never override a real slice.
  always_comb begin
    tree_eq = '1;
    tree_gt = '0;
    for (int i = 0; i < NS; i++) begin
      tree_eq[2*NP-2-i] = slice_eq[i];
      tree_gt[2*NP-2-i] = slice_gt[i];
    end
    for (int k = NP - 2; k >= 0; k--) begin
      tree_eq[k] = tree_eq[2*k+1] & tree_eq[2*k+2];
      tree_gt[k] = tree_eq[2*k+1] ? tree_gt[2*k+2] : tree_gt[2*k+1];
    end
  end

  // With equal sign bits the unsigned order of the full words matches the
  // order of the low N-1 bits, so only differing signs need correcting.
  always_comb begin
    core_res = '0;
    if (tree_eq[0]) begin
      core_res.eq = 1'b1;
    end else if (bus.is_signed && (bus.rs1[N-1] != bus.rs2[N-1])) begin
      core_res.gt = bus.rs2[N-1];
      core_res.lt = bus.rs1[N-1];
    end else begin
      core_res.gt = tree_gt[0];
      core_res.lt = ~tree_gt[0];
    end
  end

  always_comb begin
    res_d   = bus.valid_in ? core_res : res_q;
    valid_d = bus.valid_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign bus.eq        = res_q.eq;
  assign bus.gt        = res_q.gt;
  assign bus.lt        = res_q.lt;
  assign bus.valid_out = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_comparator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_comparator                                                        |
// | Table vectors, reset/hold sequences and random scoreboard regression.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_comparator;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [2:0]   exp;   // {eq, gt, lt}
    string        name;
  } vec_t;

  typedef struct {
    logic [2:0] flags;
    logic       valid;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic [2:0] last_flags = 3'b000;
  exp_t sb[$];
  vec_t vecs[$];

  comparator_if #(.N(W)) bus ();

  comparator #(.N(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got eq,gt,lt,valid=%b required %b", nm, got, want);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    if (a == b)                                  return 3'b100;
    if (s ? ($signed(a) > $signed(b)) : (a > b)) return 3'b010;
    return 3'b001;
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic v, input logic [2:0] exp_flags, input string nm);
    exp_t e;
    @(negedge clk);
    bus.rs1       = a;
    bus.rs2       = b;
    bus.is_signed = s;
    bus.valid_in  = v;
    if (v) last_flags = exp_flags;
    e.flags = last_flags;
    e.valid = v;
    e.name  = nm;
    sb.push_back(e);
  endtask

  task automatic drive_rand(input string nm);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic         v;
    int           sel;
    a   = W'($urandom);
    sel = $urandom_range(0, 9);
    if (sel == 0)      b = a;
    else if (sel == 1) b = a ^ (W'(1) << $urandom_range(0, W - 1));
    else               b = W'($urandom);
    s = 1'($urandom_range(0, 1));
    v = ($urandom_range(0, 9) != 0);
    drive(a, b, s, v, ref_cmp(a, b, s), nm);
  endtask

  // Scoreboard: one expectation per driven cycle, checked after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, {bus.eq, bus.gt, bus.lt, bus.valid_out}, {e.flags, e.valid});
      end else if (!rst) begin
        check("idle_no_output", {bus.eq, bus.gt, bus.lt, bus.valid_out},
              {last_flags, 1'b0});
      end
    end
  end

  initial begin
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.is_signed = 1'b0;
    bus.valid_in  = 1'b0;

    vecs.push_back('{16'h3524, 16'h5E81, 1'b0, 3'b001, "u_lt"});
    vecs.push_back('{16'h5E81, 16'h3524, 1'b0, 3'b010, "u_gt_swap"});
    vecs.push_back('{16'hD609, 16'hD609, 1'b0, 3'b100, "eq_u"});
    vecs.push_back('{16'hD609, 16'hD609, 1'b1, 3'b100, "eq_s"});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b0, 3'b010, "ones_vs_0_u"});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 3'b001, "ones_vs_0_s"});
    vecs.push_back('{16'h8000, 16'h7FFF, 1'b0, 3'b010, "minneg_vs_maxpos_u"});
    vecs.push_back('{16'h8000, 16'h7FFF, 1'b1, 3'b001, "minneg_vs_maxpos_s"});
    vecs.push_back('{16'h7FFF, 16'h8000, 1'b1, 3'b010, "maxpos_vs_minneg_s"});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 3'b100, "zero_eq_u"});
    vecs.push_back('{16'h0000, 16'h0000, 1'b1, 3'b100, "zero_eq_s"});
    vecs.push_back('{16'h3524, 16'h5E81, 1'b1, 3'b001, "s_pos_lt"});
    vecs.push_back('{16'hFFFE, 16'hFFFF, 1'b1, 3'b001, "s_neg_lt"});
    vecs.push_back('{16'hFFFE, 16'hFFFF, 1'b0, 3'b001, "u_high_lt"});
    vecs.push_back('{16'h0002, 16'h0001, 1'b0, 3'b010, "low_slice_gt"});
    vecs.push_back('{16'h1000, 16'h0FFF, 1'b0, 3'b010, "slice_boundary_gt"});
    vecs.push_back('{16'h0001, 16'hFFFF, 1'b1, 3'b010, "s_one_gt_neg1"});

    // Reset asserts with no clock edge in between.
    #1 rst = 1'b1;
    #2 check("reset_async_state", {bus.eq, bus.gt, bus.lt, bus.valid_out}, 4'b0000);
    repeat (2) @(posedge clk);
    #1 check("reset_held_state", {bus.eq, bus.gt, bus.lt, bus.valid_out}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    drive('0, '0, 1'b0, 1'b0, 3'b000, "post_reset_idle0");
    drive('0, '0, 1'b0, 1'b0, 3'b000, "post_reset_idle1");

    for (int i = 0; i < vecs.size(); i++)
      drive(vecs[i].a, vecs[i].b, vecs[i].s, 1'b1, vecs[i].exp, vecs[i].name);

    // Back-to-back throughput, then hold while valid_in is low.
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      a = W'($urandom);
      b = W'($urandom);
      s = 1'($urandom_range(0, 1));
      drive(a, b, s, 1'b1, ref_cmp(a, b, s), "b2b_op");
    end
    drive(16'h1234, 16'h1234, 1'b1, 1'b0, 3'b000, "hold_idle0");
    drive(16'h0000, 16'hFFFF, 1'b0, 1'b0, 3'b000, "hold_idle1");

    // Load a known nonzero result, then reset mid-cycle with an op in flight.
    drive(16'h0005, 16'h0003, 1'b0, 1'b1, 3'b010, "pre_reset_op");
    drive(16'h0001, 16'h0009, 1'b0, 1'b1, 3'b001, "inflight_op");
    #2;
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    sb.delete();
    last_flags   = 3'b000;
    #1 check("reset_midstream_async", {bus.eq, bus.gt, bus.lt, bus.valid_out}, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(16'h0001, 16'h0009, 1'b0, 1'b0, 3'b000, "post_midreset_idle0");
    drive(16'h0001, 16'h0009, 1'b0, 1'b0, 3'b000, "post_midreset_idle1");
    drive(16'hABCD, 16'hABCD, 1'b1, 1'b1, 3'b100, "first_after_reset");

    for (int i = 0; i < 11500; i++) drive_rand("random");

    drive('0, '0, 1'b0, 1'b0, 3'b000, "drain0");
    drive('0, '0, 1'b0, 1'b0, 3'b000, "drain1");
    @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
